// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and helpers for the BRAM port arbiter.
package bram_port_arbiter_pkg;

  localparam int DEF_NREQ       = 2;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin selector: picks the first asserted request at or after ptr,
// wrapping modulo NREQ. Produces a one-hot grant plus its binary index.
module rr_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = idx_width(DEF_NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Circular priority search starting at ptr; ptr is always < NREQ so a
  // single conditional subtraction performs the wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NREQ)) begin
        sum = sum - (IDX_W+1)'(NREQ);
      end
      cand = sum[IDX_W-1:0];
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one synchronous BRAM port among NREQ requesters.
//
// Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i];
// a response transfers where resp_valid[i] && resp_ready[i]. req_ready never
// rises without req_valid, and at most one req_ready bit is high per cycle.
// A single response slot (pend/pend_id) tracks the one outstanding access;
// a new access may issue only when that slot is empty or draining this cycle,
// which keeps responses in grant order and lets mem_rdata feed resp_rdata
// directly (the BRAM holds its output while mem_en is low).
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NREQ*(DATA_WIDTH/8)-1:0] req_we,
  input  logic [NREQ*DATA_WIDTH-1:0]     req_wdata,
  output logic [NREQ-1:0]                resp_valid,
  input  logic [NREQ-1:0]                resp_ready,
  output logic [DATA_WIDTH-1:0]          resp_rdata,
  output logic                           mem_en,
  output logic [DATA_WIDTH/8-1:0]        mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic [DATA_WIDTH-1:0]          mem_rdata
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int BE_W  = DATA_WIDTH / 8;

  logic             pend_q, pend_d;
  logic [IDX_W-1:0] pend_id_q, pend_id_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             resp_fire;
  logic             issue_ok;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             any_gnt;

  // Slot is free or being consumed; gating with rstn keeps req_ready low
  // asynchronously during reset.
  always_comb begin
    resp_fire = pend_q && resp_ready[pend_id_q];
    issue_ok  = rstn && (!pend_q || resp_fire);
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (issue_ok),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant drives the BRAM port; fields are zero when nothing is granted.
  always_comb begin
    any_gnt   = |gnt;
    req_ready = gnt;
    mem_en    = any_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mem_we    = req_we[i*BE_W +: BE_W];
        mem_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Response side: the slot owner sees resp_valid; read data is the BRAM output.
  always_comb begin
    resp_rdata = mem_rdata;
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i] = pend_q && (pend_id_q == IDX_W'(i));
    end
  end

  // Slot and pointer update: a new grant refills the slot (even while the old
  // response drains); a drain with no grant empties it.
  always_comb begin
    pend_d    = pend_q;
    pend_id_d = pend_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (any_gnt) begin
      pend_d    = 1'b1;
      pend_id_d = gnt_idx;
      rr_ptr_d  = (gnt_idx == IDX_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if (resp_fire) begin
      pend_d = 1'b0;
    end
  end

  // State registers; reset discards any outstanding response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q    <= 1'b0;
      pend_id_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, word address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width, a multiple of 8.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester request valid.
REQ-007 SHALL have port req_ready  output  NREQ  per-requester request accepted this cycle.
REQ-008 SHALL have port req_addr  input  NREQ*ADDR_WIDTH  packed word addresses.
REQ-009 SHALL have port req_we  input  NREQ*(DATA_WIDTH/8)  packed byte write enables; all-zero means a read.
REQ-010 SHALL have port req_wdata  input  NREQ*DATA_WIDTH  packed write data.
REQ-011 SHALL have port resp_valid  output  NREQ  per-requester response valid.
REQ-012 SHALL have port resp_ready  input  NREQ  per-requester response accept.
REQ-013 SHALL have port resp_rdata  output  DATA_WIDTH  read data, shared by all requesters, qualified by resp_valid.
REQ-014 SHALL have ports mem_en (1), mem_we (DATA_WIDTH/8), mem_addr (ADDR_WIDTH) and mem_wdata (DATA_WIDTH), all outputs, driving one synchronous BRAM port.
REQ-015 SHALL have port mem_rdata  input  DATA_WIDTH  BRAM read data, valid 1 cycle after mem_en; the BRAM holds it while mem_en is low.

Function
REQ-016 A request SHALL transfer when req_valid[i] and req_ready[i] are both high; a response SHALL transfer when resp_valid[i] and resp_ready[i] are both high.
REQ-017 At most one req_ready bit SHALL be high per cycle (one-hot grant); req_ready[i] SHALL require req_valid[i].
REQ-018 Issue SHALL be allowed when the response slot is free or is being consumed this cycle (!pend or resp_ready[pend_id]).
REQ-019 Grant SHALL be round-robin: search starts at rr_ptr and wraps modulo NREQ; after a grant to i, rr_ptr becomes (i+1) mod NREQ; with no grant rr_ptr SHALL hold.
REQ-020 mem_en SHALL equal the OR of req_ready; mem_we, mem_addr and mem_wdata SHALL be a combinational mux of the granted requester's fields, and zero when no grant.
REQ-021 Every accepted request, reads and writes alike, SHALL produce exactly one response; for writes resp_rdata is don't-care.
REQ-022 On grant, pend SHALL set and pend_id SHALL take the granted index; on response transfer with no new grant, pend SHALL clear.
REQ-023 resp_valid[i] SHALL be high iff pend and pend_id==i; resp_rdata SHALL equal mem_rdata directly, with no extra register.
REQ-024 Latency SHALL be 1 cycle from request transfer to resp_valid; back-to-back transfers SHALL sustain 1 request per cycle when responses are accepted immediately.
REQ-025 While a response is stalled (resp_ready low), mem_en SHALL stay low, so mem_rdata and resp_valid remain stable.
REQ-026 Responses SHALL return in grant order; requesters SHALL NOT need their own ordering logic.
REQ-027 A requester may keep req_valid high after a transfer; its next request competes in round-robin order.
REQ-028 Simultaneous response transfer and new grant SHALL update pend_id to the new index, with pend remaining set.

Reset
REQ-029 While rstn is low: pend=0, pend_id=0, rr_ptr=0, and req_ready, resp_valid and mem_en SHALL be 0 asynchronously.
REQ-030 Reset asserted mid-transaction SHALL drop the outstanding response silently; the first grant after release SHALL search from index 0.

Structure
REQ-031 A shared package SHALL hold the default width constants and the function that computes the index width, $clog2(NREQ) (minimum 1).
REQ-032 The round-robin selector SHALL be one sub-module, rr_arbiter (inputs: request vector, pointer, enable; outputs: one-hot grant and granted index).
REQ-033 The block SHALL connect to either port of the dual-port BRAM without glue logic.

Verification
REQ-034 Reset: hold rstn=0 with all req_valid=1 -> req_ready=0, mem_en=0, resp_valid=0.
REQ-035 Fairness: NREQ=2, both requesters continuously valid, resp_ready=1 -> grants alternate 0,1,0,1 and mem_en=1 on every cycle.
REQ-036 Read-after-write: requester 0 writes 0xDEADBEEF to address 0x10 with we=4'hF, then requester 1 reads 0x10 -> resp_valid[1] one cycle after grant with resp_rdata=0xDEADBEEF.
REQ-037 Byte merge: write 0x11223344 with we=4'hF, then 0xAA000000 with we=4'h8, then read -> 0xAA223344.
REQ-038 Backpressure: hold resp_ready[0]=0 for 5 cycles after a read -> req_ready all 0, mem_en 0, resp_rdata stable; release -> resp transfers and a new grant occurs in the same cycle.
REQ-039 Mid-operation reset: assert rstn=0 while pend=1 -> resp_valid drops immediately; after release the first grant goes to requester 0.
